// File: rtl/fft_twiddle_gen.sv
// fft_twiddle_gen: streams one radix-2 DIT FFT stage's twiddle factors from a folded quarter-wave cosine table
module fft_twiddle_gen #(
  parameter int N_LOG2 = 5,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  localparam int SW = (N_LOG2 > 2) ? $clog2(N_LOG2) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SW-1:0]     stage,
  input  logic              inverse,
  output logic              busy,
  output logic              cfg_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [N_LOG2-2:0] out_k,
  output logic              out_last
);
  localparam int KW = N_LOG2 - 1;
  localparam int N = 1 << N_LOG2;
  localparam logic [KW-1:0] QTR = KW'(N / 4);

  // Quantised first-quadrant cosine, evaluated at elaboration by Taylor series
  function automatic logic [DATA_W-1:0] cos_q(input int m);
    real x, t, s;
    x = 6.283185307179586 * m / N;
    t = 1.0;
    s = 1.0;
    for (int i = 1; i < 14; i++) begin
      t = -t * x * x / ((2 * i - 1) * (2 * i));
      s = s + t;
    end
    return DATA_W'($rtoi(s * (1 << FRAC_W) + 0.5));
  endfunction

  logic [DATA_W-1:0] c_tab [N/4+1];
  for (genvar g = 0; g <= N / 4; g++) begin : g_tab
    localparam logic [DATA_W-1:0] CV = cos_q(g);
    assign c_tab[g] = CV;
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, next;

  logic [SW-1:0] s_q;
  logic          inv_q;
  logic [KW-1:0] b, k_iss, k1, ca1, sa1;
  logic          v1, last1, hi1, adv, legal, hi;

  assign adv   = !out_valid || out_ready;
  assign legal = int'(stage) < N_LOG2;
  assign busy  = state != IDLE;
  assign k_iss = (b & ~({KW{1'b1}} << s_q)) << (KW - int'(s_q));
  assign hi    = k_iss >= QTR;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;

  // Next state: legal start launches, last issue drains, final handshake returns to idle
  always_comb begin
    next = state;
    if (state == IDLE && start && legal) next = RUN;
    else if (state == RUN && adv && &b) next = DRAIN;
    else if (state == DRAIN && out_valid && out_ready && out_last) next = IDLE;
  end

  // Latched stage config, butterfly counter and illegal-stage error pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_q     <= '0;
      inv_q   <= 1'b0;
      b       <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= state == IDLE && start && !legal;
      if (state == IDLE && start && legal) begin
        s_q   <= stage;
        inv_q <= inverse;
        b     <= '0;
      end else if (state == RUN && adv) b <= b + 1'b1;
    end

  // Two-stage pipeline: P1 forms k and fold addresses, P2 reads the table and applies signs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1        <= 1'b0;
      k1        <= '0;
      last1     <= 1'b0;
      hi1       <= 1'b0;
      ca1       <= '0;
      sa1       <= '0;
      out_valid <= 1'b0;
      out_k     <= '0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else if (adv) begin
      v1        <= state == RUN;
      k1        <= k_iss;
      last1     <= state == RUN && &b;
      hi1       <= hi;
      ca1       <= hi ? QTR - (k_iss - QTR) : k_iss;
      sa1       <= hi ? k_iss - QTR : QTR - k_iss;
      out_valid <= v1;
      out_k     <= k1;
      out_last  <= last1 && v1;
      out_re    <= hi1 ? -c_tab[ca1] : c_tab[ca1];
      out_im    <= inv_q ? c_tab[sa1] : -c_tab[sa1];
    end
endmodule

// File: tb/tb_fft_twiddle_gen.sv
// tb_fft_twiddle_gen: randomized scoreboard bench for fft_twiddle_gen against a trig reference model
module tb_fft_twiddle_gen;
  localparam int NL = 5;
  localparam int DW = 16;
  localparam int FW = 8;
  localparam int N = 1 << NL;

  logic          clk = 0, rst_n = 0, start = 0, inverse = 0, out_ready = 1;
  logic [2:0]    stage = '0;
  logic          busy, cfg_err, out_valid, out_last;
  logic [DW-1:0] out_re, out_im;
  logic [NL-2:0] out_k;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [NL-2:0] k;
    logic          last;
  } exp_t;

  exp_t q[$];
  exp_t e;
  exp_t held;
  bit   hv = 0, rand_rdy = 0, last_hs = 0;
  int   n_chk = 0, n_fail = 0, popped = 0;

  fft_twiddle_gen #(.N_LOG2(NL), .DATA_W(DW), .FRAC_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stage(stage), .inverse(inverse),
    .busy(busy), .cfg_err(cfg_err), .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_k(out_k), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic int rnd(real x);
    return x >= 0.0 ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  // Expected twiddle for butterfly b of stage s, straight from W_N^k = cos - j sin
  function automatic exp_t model(int s, int b, bit inv);
    exp_t r;
    int   k;
    real  a, sc;
    k  = (b % (1 << s)) * (1 << (NL - 1 - s));
    a  = 2.0 * 3.141592653589793 * k / N;
    sc = real'(1 << FW);
    r.re   = DW'(rnd(sc * $cos(a)));
    r.im   = DW'(inv ? rnd(sc * $sin(a)) : -rnd(sc * $sin(a)));
    r.k    = (NL-1)'(k);
    r.last = b == N / 2 - 1;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pop and compare on every handshake, and check outputs hold during stalls
  always @(negedge clk) begin
    if (!rst_n) hv = 0;
    else begin
      if (hv) chk("stall_hold", {out_re, out_im, out_k, out_last}, held);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got k=%0d expected none", out_k);
        end else begin
          e = q.pop_front();
          chk("out_re", out_re, e.re);
          chk("out_im", out_im, e.im);
          chk("out_k", out_k, e.k);
          chk("out_last", out_last, e.last);
          popped++;
          if (out_last) last_hs = 1;
        end
      end
      hv   = out_valid && !out_ready;
      held = {out_re, out_im, out_k, out_last};
    end
  end

  // Ready driver: always ready, or about 30% low when randomized
  initial forever begin
    @(posedge clk);
    #1 out_ready = rand_rdy ? ($urandom_range(0, 9) >= 3) : 1'b1;
  end

  task automatic run(int s, bit inv, bit hit_busy);
    bit done;
    @(posedge clk);
    #1 start = 1;
    stage   = 3'(s);
    inverse = inv;
    for (int b = 0; b < N / 2; b++) q.push_back(model(s, b, inv));
    last_hs = 0;
    @(posedge clk);
    #1 start = 0;
    chk("busy_after_start", busy, 1);
    chk("valid_at_T", out_valid, 0);
    @(posedge clk);
    #1 chk("valid_at_T1", out_valid, 0);
    if (hit_busy) begin
      start   = 1;
      stage   = 3'((s + 1) % NL);
      inverse = ~inv;
    end
    @(posedge clk);
    #1 start = 0;
    chk("valid_at_T2", out_valid, 1);
    done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(posedge clk);
      #1 if (!busy) begin
        start = 0;
        done  = 1;
      end else begin
        if (last_hs) chk("busy_fall_late", busy, 0);
        if (hit_busy) start = 1;
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL stream_timeout: got busy=1 expected busy=0 within 500 cycles");
      start = 0;
    end
    chk("busy_fall_with_last", last_hs, 1);
    chk("queue_drained", q.size(), 0);
    q.delete();
    @(posedge clk);
    #1 chk("idle_after_stream", busy, 0);
    chk("no_extra_valid", out_valid, 0);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1 chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", {out_re, out_im, out_k, out_last}, 0);
    rst_n = 1;
    run(4, 0, 0);
    run(4, 1, 0);
    run(0, 0, 0);
    run(2, 0, 0);
    run(3, 0, 1);
    rand_rdy = 1;
    run(4, 0, 0);
    run(4, 1, 1);
    rand_rdy = 0;
    @(posedge clk);
    #1 start = 1;
    stage = 3'd5;
    @(posedge clk);
    #1 start = 0;
    chk("cfg_err_pulse", cfg_err, 1);
    chk("cfg_err_busy", busy, 0);
    @(posedge clk);
    #1 chk("cfg_err_clear", cfg_err, 0);
    repeat (3) begin
      @(posedge clk);
      #1 chk("cfg_err_no_valid", out_valid, 0);
    end
    @(posedge clk);
    #1 start = 1;
    stage   = 3'd4;
    inverse = 0;
    for (int b = 0; b < N / 2; b++) q.push_back(model(4, b, 0));
    @(posedge clk);
    #1 start = 0;
    base = popped;
    for (int i = 0; i < 200 && popped < base + 7; i++) @(negedge clk);
    if (popped < base + 7) begin
      n_chk++;
      n_fail++;
      $display("FAIL reset_wait: got %0d outputs expected 7", popped - base);
    end
    #2 rst_n = 0;
    #1 chk("async_rst_data", {out_re, out_im, out_k, out_last}, 0);
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    q.delete();
    @(posedge clk);
    #1 rst_n = 1;
    run(3, 0, 0);
    rand_rdy = 1;
    repeat (6) run($urandom_range(0, NL - 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rand_rdy = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_twiddle_gen.md
# fft_twiddle_gen

Parametrised twiddle-factor sequencer for the radix-2 DIT FFT datapath. On a start command for a given stage it streams the N/2 complex twiddles W_N^k = cos(2πk/N) ∓ j·sin(2πk/N) needed by that stage, one per cycle, over a valid/ready handshake. It replaces the fixed 32-entry per-part twiddle ROMs: one quarter-wave cosine table plus symmetry folding yields both real and imaginary parts for any N, with a forward/inverse mode.

## Interface
- N_LOG2, 5: log2 of FFT size N, legal 3..12.
- DATA_W, 16: two's-complement output width.
- FRAC_W, 8: fractional bits; +1.0 = 2^FRAC_W, requires FRAC_W ≤ DATA_W-2.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command; accepted only when busy=0.
- stage  in  N_LOG2 bits (width $clog2(N_LOG2) min 1)  FFT stage s, 0..N_LOG2-1.
- inverse  in  1  1: conjugate twiddles (IFFT); sampled with start.
- busy  out  1  high from accepted start until last output handshake.
- cfg_err  out  1  one-cycle pulse when start arrives with stage ≥ N_LOG2 while idle.
- out_valid  out  1  twiddle present on outputs.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_re  out  DATA_W  real part.
- out_im  out  DATA_W  imaginary part.
- out_k  out  N_LOG2-1  twiddle exponent k of the current output.
- out_last  out  1  high with final twiddle of the stage.

## Operation
- Table C[m], m=0..N/4, = round-half-away(2^FRAC_W·cos(2πm/N)), constant computed at elaboration, sign-extended to DATA_W.
- States: IDLE, RUN, DRAIN. IDLE: start & legal stage → latch s, inverse; b←0; RUN. start & illegal stage → cfg_err pulse, stay IDLE. start while busy is ignored (no error).
- RUN: per pipeline advance, issue butterfly index b; k = (b mod 2^s) << (N_LOG2-1-s); b increments; after b = N/2-1 issued → DRAIN.
- DRAIN: wait until last element (out_last) handshakes → IDLE, busy←0 same edge.
- Fold for k in 0..N/2-1: k < N/4: cos=C[k], sin=C[N/4-k]; k ≥ N/4, m=k-N/4: cos=-C[N/4-m], sin=C[m].
- out_re = cos; out_im = -sin (forward) or +sin (inverse). Negation in DATA_W; no overflow since |value| ≤ 2^FRAC_W.
- out_last = 1 for b = N/2-1 only.

## Timing
- Reset: state IDLE, busy=0, cfg_err=0, out_valid=0, out_re=out_im=out_k=out_last=0, counters 0. Reset mid-stream aborts immediately; no partial output after release.
- Two-stage pipeline: P1 computes k and table address, P2 registers table read + fold to outputs.
- Latency: start accepted at edge T → busy=1 after T; first out_valid=1 after edge T+2.
- Throughput: one twiddle per cycle while out_ready=1; stage s emits exactly N/2 outputs.
- Backpressure: whole pipeline advances iff !out_valid | out_ready. While out_valid & !out_ready, out_re/out_im/out_k/out_last hold stable and no b increments.
- busy falls on the edge where out_last handshakes; a start in that same cycle is ignored; next start accepted the following cycle.
- cfg_err registered: asserts the cycle after the illegal start, for one cycle.

## Test plan
- N_LOG2=5, FRAC_W=8, stage=4, forward, out_ready=1 → 16 outputs k=0..15, first at T+2; k=0: re=0x0100, im=0x0000; k=4: re=0x00B5, im=0xFF4B; k=8: re=0x0000, im=0xFF00; k=12: re=0xFF4B, im=0xFF4B; out_last only on k=15; busy low after it.
- Same, inverse=1 → identical re; k=8 im=0x0100, k=1 im=0x0032.
- stage=0 → 16 outputs all k=0 (re=0x0100, im=0); stage=2 → k sequence 0,4,8,12 repeated 4 times.
- Random out_ready (30% low) on stage=4 → sequence, values and count identical to unstalled run; outputs stable during every stall.
- stage=5 while idle → cfg_err one-cycle pulse, busy stays 0, no out_valid; start during busy → ignored, stream unchanged.
- rst_n low at output 7 → all outputs zero asynchronously; after release, new start stage=3 produces full 16-element stream from b=0.
